clock_set_ctrl: RTL

//  Time-setting controller for the 6-digit HH:MM:SS clock (BCD counter + 7-seg scan).

---
 rtl/clock_set_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the HH:MM:SS BCD clock: RUN -> SET_H -> SET_M -> SET_S -> COMMIT.
// Latency: a key pulse in cycle N updates state, edit registers and all outputs in cycle N+1.
// No backpressure: keys are 1-cycle pulses; keys seen in RUN (except mode) or in COMMIT are dropped.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_mode/inc/dec    debounced 1-cycle key pulses
//   tick_1s             1-cycle pulse per second (drives the edit timeout)
//   cur_*               live counter digits, captured on edit entry
//   run_en, load        counter control (load is a 1-cycle pulse in COMMIT)
//   ld_*                edited time in BCD, valid while load=1
//   blank_mask          per-digit blanking for the scanner (bit5..0 = s_s,s_g,f_s,f_g,m_s,m_g)
//   set_active          1 in any edit state or COMMIT
module clock_set_ctrl #(
  parameter int BLINK_HALF = 12_500_000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       tick_1s,
  input  logic [1:0] cur_s_s,
  input  logic [3:0] cur_s_g,
  input  logic [2:0] cur_f_s,
  input  logic [3:0] cur_f_g,
  input  logic [2:0] cur_m_s,
  input  logic [3:0] cur_m_g,
  output logic       run_en,
  output logic       load,
  output logic [1:0] ld_s_s,
  output logic [3:0] ld_s_g,
  output logic [2:0] ld_f_s,
  output logic [3:0] ld_f_g,
  output logic [2:0] ld_m_s,
  output logic [3:0] ld_m_g,
  output logic [5:0] blank_mask,
  output logic       set_active
);

  localparam int                BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF + 1) : 1;
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [7:0]        TO_LAST    = 8'(TIMEOUT_S - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;     // cycles into the current blink half-period
  logic          hidden, hidden_n; // blink phase: 1 = selected field blanked
  logic [7:0]    tcnt, tcnt_n;     // seconds without an accepted key

  logic [1:0]    ld_s_s_n;
  logic [3:0]    ld_s_g_n;
  logic [2:0]    ld_f_s_n;
  logic [3:0]    ld_f_g_n;
  logic [2:0]    ld_m_s_n;
  logic [3:0]    ld_m_g_n;

  logic          run_en_n;
  logic          load_n;
  logic          set_active_n;
  logic [5:0]    blank_mask_n;

  logic          step;
  logic [5:0]    hour_nxt;
  logic [6:0]    min_nxt;
  logic [6:0]    sec_nxt;

  // Hour pair 00..23 with wrap; no carry leaves the field.
  function automatic logic [5:0] hour_step(input logic [1:0] t, input logic [3:0] u,
                                           input logic up);
    logic [5:0] r;
    if (up) begin
      if (t == 2'd2 && u == 4'd3)      r = 6'd0;
      else if (u == 4'd9)              r = {t + 2'd1, 4'd0};
      else                             r = {t, u + 4'd1};
    end else begin
      if (t == 2'd0 && u == 4'd0)      r = {2'd2, 4'd3};
      else if (u == 4'd0)              r = {t - 2'd1, 4'd9};
      else                             r = {t, u - 4'd1};
    end
    return r;
  endfunction

  // Minute/second pair 00..59 with wrap; no carry leaves the field.
  function automatic logic [6:0] sexa_step(input logic [2:0] t, input logic [3:0] u,
                                           input logic up);
    logic [6:0] r;
    if (up) begin
      if (t == 3'd5 && u == 4'd9)      r = 7'd0;
      else if (u == 4'd9)              r = {t + 3'd1, 4'd0};
      else                             r = {t, u + 4'd1};
    end else begin
      if (t == 3'd0 && u == 4'd0)      r = {3'd5, 4'd9};
      else if (u == 4'd0)              r = {t - 3'd1, 4'd9};
      else                             r = {t, u - 4'd1};
    end
    return r;
  endfunction

  // inc and dec together cancel and count as no key at all.
  assign step     = key_inc ^ key_dec;
  assign hour_nxt = hour_step(ld_s_s, ld_s_g, key_inc);
  assign min_nxt  = sexa_step(ld_f_s, ld_f_g, key_inc);
  assign sec_nxt  = sexa_step(ld_m_s, ld_m_g, key_inc);

  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    hidden_n = hidden;
    tcnt_n   = tcnt;
    ld_s_s_n = ld_s_s;
    ld_s_g_n = ld_s_g;
    ld_f_s_n = ld_f_s;
    ld_f_g_n = ld_f_g;
    ld_m_s_n = ld_m_s;
    ld_m_g_n = ld_m_g;

    case (state)
      RUN: begin
        if (key_mode) begin
          state_n  = SET_H;
          ld_s_s_n = cur_s_s;
          ld_s_g_n = cur_s_g;
          ld_f_s_n = cur_f_s;
          ld_f_g_n = cur_f_g;
          ld_m_s_n = cur_m_s;
          ld_m_g_n = cur_m_g;
          bcnt_n   = '0;
          hidden_n = 1'b0;
          tcnt_n   = '0;
        end
      end

      SET_H, SET_M, SET_S: begin
        if (key_mode) begin
          case (state)
            SET_H:   state_n = SET_M;
            SET_M:   state_n = SET_S;
            default: state_n = COMMIT;
          endcase
          bcnt_n   = '0;
          hidden_n = 1'b0;
          tcnt_n   = '0;
        end else if (step) begin
          case (state)
            SET_H:   {ld_s_s_n, ld_s_g_n} = hour_nxt;
            SET_M:   {ld_f_s_n, ld_f_g_n} = min_nxt;
            default: {ld_m_s_n, ld_m_g_n} = sec_nxt;
          endcase
          bcnt_n   = '0;
          hidden_n = 1'b0;
          tcnt_n   = '0;
        end else begin
          if (bcnt == BLINK_LAST) begin
            bcnt_n   = '0;
            hidden_n = ~hidden;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
          // A key in the same cycle as the final tick is handled above and wins.
          if (tick_1s) begin
            if (tcnt == TO_LAST) begin
              state_n  = RUN;
              tcnt_n   = '0;
              bcnt_n   = '0;
              hidden_n = 1'b0;
            end else begin
              tcnt_n = tcnt + 8'd1;
            end
          end
        end
      end

      COMMIT:  state_n = RUN;
      default: state_n = RUN;
    endcase

    // Outputs are registered copies of what the next state implies.
    run_en_n     = (state_n == RUN);
    load_n       = (state_n == COMMIT);
    set_active_n = (state_n != RUN);
    case (state_n)
      SET_H:   blank_mask_n = hidden_n ? 6'b110000 : 6'b000000;
      SET_M:   blank_mask_n = hidden_n ? 6'b001100 : 6'b000000;
      SET_S:   blank_mask_n = hidden_n ? 6'b000011 : 6'b000000;
      default: blank_mask_n = 6'b000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      bcnt       <= '0;
      hidden     <= 1'b0;
      tcnt       <= '0;
      ld_s_s     <= '0;
      ld_s_g     <= '0;
      ld_f_s     <= '0;
      ld_f_g     <= '0;
      ld_m_s     <= '0;
      ld_m_g     <= '0;
      run_en     <= 1'b1;
      load       <= 1'b0;
      set_active <= 1'b0;
      blank_mask <= '0;
    end else begin
      state      <= state_n;
      bcnt       <= bcnt_n;
      hidden     <= hidden_n;
      tcnt       <= tcnt_n;
      ld_s_s     <= ld_s_s_n;
      ld_s_g     <= ld_s_g_n;
      ld_f_s     <= ld_f_s_n;
      ld_f_g     <= ld_f_g_n;
      ld_m_s     <= ld_m_s_n;
      ld_m_g     <= ld_m_g_n;
      run_en     <= run_en_n;
      load       <= load_n;
      set_active <= set_active_n;
      blank_mask <= blank_mask_n;
    end
  end

endmodule
